// File: rtl/dec24_if.sv
// Handshake and output bundle for the dec24_seq one-hot decoder.
// master = code producer / consumer of the select lines, slave = the decoder.
interface dec24_if;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] i;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    modport master (
        output en, in_valid, i,
        input  in_ready, y, busy, done, dbg_state
    );

    modport slave (
        input  en, in_valid, i,
        output in_ready, y, busy, done, dbg_state
    );
endinterface

// File: rtl/dec24_seq.sv
// Registered 2-to-4 one-hot decoder: buffers 2-bit codes in a small FIFO and
// plays each one out as a HOLD-cycle one-hot pulse followed by a one-cycle gap.
module dec24_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 2
) (
    input logic    clk,
    input logic    rst_n,
    dec24_if.slave bus
);
    // Handshake: a code transfers at a rising edge when in_valid && in_ready.
    // in_ready comes only from registered occupancy and en, never from in_valid.
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic [3:0]    y_q;
    logic          done_q;
    logic          init_q;
    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [1:0]    head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = mem_q[rd_q[AW-1:0]];

    assign bus.in_ready = init_q && !full && bus.en;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.en && !empty && (state_q != S_DRIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= bus.i;
    end

    // The decoded value lives in y_q through en-low stretches, so output
    // blanking never loses the code or the remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        y_q     <= 4'b0001 << head;
                        cnt_q   <= 8'(HOLD - 1);
                        state_q <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == 8'd0) begin
                        y_q     <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_GAP: begin
                    done_q <= 1'b0;
                    if (!empty) begin
                        y_q     <= 4'b0001 << head;
                        cnt_q   <= 8'(HOLD - 1);
                        state_q <= S_DRIVE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.y         = bus.en ? y_q : 4'b0000;
    assign bus.done      = bus.en && done_q;
    assign bus.busy      = (state_q != S_IDLE) || !empty;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dec24_seq.sv
// Bench for dec24_seq: two instances (HOLD=4 and HOLD=1) share stimulus and are
// checked every cycle against a queue-based playout model, plus literal checks.
module tb_dec24_seq;
  localparam int DEPTH = 2;
  localparam int HOLD0 = 4;
  localparam int HOLD1 = 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [1:0] code;

  dec24_if if0 ();
  dec24_if if1 ();

  assign if0.en = en;
  assign if0.in_valid = in_valid;
  assign if0.i = code;
  assign if1.en = en;
  assign if1.in_valid = in_valid;
  assign if1.i = code;

  dec24_seq #(.HOLD(HOLD0), .DEPTH(DEPTH)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dec24_seq #(.HOLD(HOLD1), .DEPTH(DEPTH)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per instance a code FIFO and a playout stream of {done,y}
  logic [3:0] onehot_tab [4];
  logic [1:0] mfifo   [2][$];
  logic [4:0] mstream [2][$];
  logic [4:0] mcur [2];
  logic       mact [2];
  logic       minit [2];
  logic       m_rdy;
  logic [1:0] m_code;

  initial begin
    onehot_tab[0] = 4'b0001;
    onehot_tab[1] = 4'b0010;
    onehot_tab[2] = 4'b0100;
    onehot_tab[3] = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      mcur[k] = '0;
      mact[k] = 1'b0;
      minit[k] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          mfifo[k].delete();
          mstream[k].delete();
          mcur[k] = '0;
          mact[k] = 1'b0;
          minit[k] = 1'b0;
        end else if (!minit[k]) begin
          minit[k] = 1'b1;
        end else if (en) begin
          m_rdy = (mfifo[k].size() < DEPTH);
          if (mstream[k].size() == 0 && mfifo[k].size() != 0) begin
            m_code = mfifo[k].pop_front();
            for (int h = 0; h < ((k == 0) ? HOLD0 : HOLD1); h++)
              mstream[k].push_back({1'b0, onehot_tab[m_code]});
            mstream[k].push_back(5'b10000);
          end
          if (mstream[k].size() != 0) begin
            mcur[k] = mstream[k].pop_front();
            mact[k] = 1'b1;
          end else begin
            mcur[k] = '0;
            mact[k] = 1'b0;
          end
          if (in_valid && m_rdy) mfifo[k].push_back(code);
        end
      end
    end
  end

  task automatic chk_inst(input int k, input logic [3:0] y, input logic d,
                          input logic b, input logic r);
    logic [3:0] ey;
    logic       ed;
    logic       eb;
    logic       er;
    ey = en ? mcur[k][3:0] : 4'b0000;
    ed = en & mcur[k][4];
    eb = mact[k] || (mfifo[k].size() != 0);
    er = minit[k] && (mfifo[k].size() < DEPTH) && en;
    chk($sformatf("u%0d.y", k), {4'b0, y}, {4'b0, ey});
    chk($sformatf("u%0d.done", k), {7'b0, d}, {7'b0, ed});
    chk($sformatf("u%0d.busy", k), {7'b0, b}, {7'b0, eb});
    chk($sformatf("u%0d.in_ready", k), {7'b0, r}, {7'b0, er});
  endtask

  // compare process, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk_inst(0, if0.y, if0.done, if0.busy, if0.in_ready);
      chk_inst(1, if1.y, if1.done, if1.busy, if1.in_ready);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(input logic [1:0] c);
    int guard;
    guard = 0;
    code = c;
    in_valid = 1'b1;
    while (!if0.in_ready && guard < 100) begin
      step();
      guard++;
    end
    chk("push_wait_ready", {7'b0, if0.in_ready}, 8'd1);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    code = 2'd0;
    repeat (3) step();
    chk("reset_y", {4'b0, if0.y}, 8'h00);
    chk("reset_busy", {7'b0, if0.busy}, 8'h00);
    chk("reset_ready", {7'b0, if0.in_ready}, 8'h00);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", {7'b0, if0.in_ready}, 8'h01);

    // single code 2 with HOLD=4
    in_valid = 1'b1;
    code = 2'd2;
    step();
    in_valid = 1'b0;
    chk("t1_not_yet", {4'b0, if0.y}, 8'h00);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t1_y_hold", {4'b0, if0.y}, 8'h04);
    end
    step();
    chk("t1_gap_y", {4'b0, if0.y}, 8'h00);
    chk("t1_gap_done", {7'b0, if0.done}, 8'h01);
    step();
    chk("t1_idle_busy", {7'b0, if0.busy}, 8'h00);
    repeat (3) step();

    // streaming 0..3 with back-pressure
    for (int c = 0; c < 4; c++) push_wait(2'(c));
    in_valid = 1'b0;
    repeat (30) step();

    // en dropped mid-DRIVE
    push_wait(2'd1);
    in_valid = 1'b0;
    step();
    chk("t4_drive1", {4'b0, if0.y}, 8'h02);
    step();
    chk("t4_drive2", {4'b0, if0.y}, 8'h02);
    step();
    en = 1'b0;
    #1;
    chk("t4_blank_y", {4'b0, if0.y}, 8'h00);
    chk("t4_blank_ready", {7'b0, if0.in_ready}, 8'h00);
    repeat (5) step();
    en = 1'b1;
    #1;
    chk("t4_resume1", {4'b0, if0.y}, 8'h02);
    step();
    chk("t4_resume2", {4'b0, if0.y}, 8'h02);
    step();
    chk("t4_gap_y", {4'b0, if0.y}, 8'h00);
    chk("t4_gap_done", {7'b0, if0.done}, 8'h01);
    repeat (15) step();

    // asynchronous reset mid-DRIVE
    push_wait(2'd3);
    in_valid = 1'b1;
    code = 2'd1;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_y", {4'b0, if0.y}, 8'h00);
    chk("t5_rst_busy", {7'b0, if0.busy}, 8'h00);
    chk("t5_rst_ready", {7'b0, if0.in_ready}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_flushed_busy", {7'b0, if0.busy}, 8'h00);
    push_wait(2'd0);
    in_valid = 1'b0;
    step();
    chk("t5_next_code", {4'b0, if0.y}, 8'h01);
    repeat (15) step();

    // HOLD=1 instance: codes 3,0 back-to-back
    in_valid = 1'b1;
    code = 2'd3;
    step();
    code = 2'd0;
    step();
    in_valid = 1'b0;
    chk("t6_y0", {4'b0, if1.y}, 8'h08);
    chk("t6_d0", {7'b0, if1.done}, 8'h00);
    step();
    chk("t6_y1", {4'b0, if1.y}, 8'h00);
    chk("t6_d1", {7'b0, if1.done}, 8'h01);
    step();
    chk("t6_y2", {4'b0, if1.y}, 8'h01);
    step();
    chk("t6_y3", {4'b0, if1.y}, 8'h00);
    chk("t6_d3", {7'b0, if1.done}, 8'h01);
    repeat (15) step();

    // randomized traffic with en toggling
    for (int n = 0; n < 800; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      code = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      step();
    end
    en = 1'b1;
    in_valid = 1'b0;
    repeat (30) step();
    chk("final_idle_busy0", {7'b0, if0.busy}, 8'h00);
    chk("final_idle_busy1", {7'b0, if1.busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dec24_seq.md
Name: dec24_seq

Overview:
- Registered 2-to-4 one-hot decoder. It is the receive-side counterpart of the enco42 4-to-2 encoder.
- Accepts 2-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Plays each code out as a one-hot 4-bit pulse lasting HOLD cycles, followed by a mandatory one-cycle all-zero gap.
- Drives one-hot select lines downstream of the encoder path.

Parameters:
- HOLD, default 4: cycles each one-hot output stays asserted. Legal range 1..255.
- DEPTH, default 2: input FIFO entries. Legal values are powers of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  enable. When low, the block is frozen and outputs are blanked.
- in_valid  input  1  code i is valid this cycle.
- in_ready  output  1  FIFO can accept. Equals (!full && en).
- i  input  2  code to decode. 0→0001, 1→0010, 2→0100, 3→1000.
- y  output  4  registered one-hot output. 4'b0000 when not driving.
- busy  output  1  high in DRIVE or GAP, or when the FIFO is non-empty.
- done  output  1  one-cycle pulse, high during the GAP cycle after each code.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, state IDLE, hold counter 0.
  - Outputs: y=0000, done=0, busy=0, in_ready=0 while reset is asserted. in_ready goes to 1 from the first cycle after deassertion, provided en=1.
  - Reset mid-DRIVE drops y to 0000 immediately and discards all buffered codes.
- Handshake:
  - A push occurs at a rising edge when in_valid && in_ready. i is sampled at that edge.
  - in_ready depends only on registered FIFO occupancy and en. There is no combinational path from in_valid.
  - When the FIFO is full, no push occurs, even if a pop happens in the same cycle.
  - If a push and a pop happen in the same cycle with occupancy between 1 and DEPTH-1, occupancy is unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: y=0000. If the FIFO is non-empty, pop the head, load y with the decoded value, load counter=HOLD-1, and go to DRIVE.
  - DRIVE: y holds the one-hot value. If counter==0, go to GAP with y←0000 and done←1. Otherwise decrement the counter.
  - GAP: lasts exactly one cycle with y=0000 and done=1.
    - If the FIFO is non-empty, pop, load y and counter, and go to DRIVE.
    - Otherwise go to IDLE.
- Timing:
  - A code pushed at edge N into an empty, idle block is popped at edge N+1. It drives y from edge N+1 for exactly HOLD cycles, and then y=0000 for at least one cycle.
  - Back-to-back throughput is one code per HOLD+1 cycles.
  - With HOLD=1, y alternates between a one-hot value and 0000 on successive cycles.
- en:
  - While en=0: state, counter, and FIFO contents are held, no push and no pop occur, y reads 0000, and done=0.
  - When en returns to 1, DRIVE resumes with the remaining count. The decoded value is restored from a held register, so the total active cycles still equal HOLD.
  - en falling during GAP: the GAP completes when en returns. done is asserted on that cycle.
- Invariants:
  - y is always one-hot or zero; no two bits are ever set.
  - done is never high while y is non-zero.
  - FIFO read and write pointers wrap modulo DEPTH. Occupancy is tracked with an extra bit so full and empty are distinguishable.

Test Plan:
1. Reset, then en=1 and push i=2 at edge 1 with HOLD=4 → y=0100 for cycles 2–5, y=0000 with done=1 at cycle 6, then IDLE with busy=0.
2. Stream codes 0,1,2,3 with in_valid held high → y steps 0001, 0010, 0100, 1000, each for 4 cycles with a 1-cycle gap between them. in_ready drops when occupancy hits 2. No code is lost or duplicated.
3. Push 3 codes while in DRIVE with DEPTH=2 → the third push is refused (in_ready=0) until the first pop. All accepted codes are output in order.
4. Push i=1, then drop en after 2 DRIVE cycles for 5 cycles → y=0000 and in_ready=0 while en is low. After en returns, y=0010 for the remaining 2 cycles, followed by the gap and done pulse.
5. Assert rst_n low mid-DRIVE between clock edges → y=0000 and busy=0 immediately. After release, the FIFO is empty and the next push decodes normally.
6. Run with HOLD=1 and push codes 3,0 back-to-back → y sequence is 1000, 0000, 0001, 0000, with done high on both zero cycles.
